pe_mult_pipe: RTL and testbench

Pipelined, parametrised successor to the parallel PE multiplier array. Multiplies LANES neuron/weight operand pairs per beat, with per-beat selection of full-width or dual half-width (int16 / 2×int8 at default width) mode and signed/unsigned arithmetic. It sits between the operand fetch buffers and the PE adder tree. Valid/ready handshakes on both sides give full throughput and lossless backpressure.

---
 rtl/pe_pkg.sv | 21 ++
 rtl/pe_mult_lane.sv | 67 ++++++
 rtl/pe_mult_pipe.sv | 133 +++++++++++++
 tb/tb_pe_mult_pipe.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// -----------------------------------------------------------------------------
// pe_pkg
// Shared definitions for the pipelined PE multiplier array.
//   MODE_FULL / MODE_HALF : per-beat multiply mode encodings
//   PE_LANES / PE_DW      : default lane count and operand width
//   res_w()               : result width of one lane (twice the operand width)
// -----------------------------------------------------------------------------
package pe_pkg;

   localparam logic MODE_FULL = 1'b0;
   localparam logic MODE_HALF = 1'b1;

   localparam int PE_LANES = 32;
   localparam int PE_DW    = 16;

   // Width of one lane result for a DW-bit operand pair.
   function automatic int res_w(input int dw);
      return 2 * dw;
   endfunction

endpackage

// File: rtl/pe_mult_lane.sv
// -----------------------------------------------------------------------------
// pe_mult_lane
// One combinational multiplier lane.
//   mode   in  1       MODE_FULL: one DW x DW product
//                      MODE_HALF: two independent DW/2 x DW/2 products
//   sign   in  1       1 = operands are two's complement, 0 = unsigned
//   neuron in  DW      first operand
//   weight in  DW      second operand
//   result out 2*DW    full: exact product
//                      half: {hi product, lo product}, each exactly DW bits
// -----------------------------------------------------------------------------
module pe_mult_lane
   import pe_pkg::*;
#(
   parameter int DW = PE_DW
) (
   input  logic                 mode,
   input  logic                 sign,
   input  logic [DW-1:0]        neuron,
   input  logic [DW-1:0]        weight,
   output logic [res_w(DW)-1:0] result
);

   localparam int HW = DW / 2;
   localparam int RW = res_w(DW);

   // Operands extended to the product width. Extending by the operand sign
   // bit (only when signed) and multiplying modulo 2^width gives the exact
   // two's-complement or unsigned product in the low bits.
   logic [RW-1:0] full_n_s;
   logic [RW-1:0] full_w_s;
   logic [RW-1:0] full_p_s;
   logic [DW-1:0] lo_n_s;
   logic [DW-1:0] lo_w_s;
   logic [DW-1:0] lo_p_s;
   logic [DW-1:0] hi_n_s;
   logic [DW-1:0] hi_w_s;
   logic [DW-1:0] hi_p_s;

   // Operand extension for the full-width and both half-width products.
   always_comb begin
      full_n_s = {{DW{sign & neuron[DW-1]}}, neuron};
      full_w_s = {{DW{sign & weight[DW-1]}}, weight};
      lo_n_s   = {{HW{sign & neuron[HW-1]}}, neuron[HW-1:0]};
      lo_w_s   = {{HW{sign & weight[HW-1]}}, weight[HW-1:0]};
      hi_n_s   = {{HW{sign & neuron[DW-1]}}, neuron[DW-1:HW]};
      hi_w_s   = {{HW{sign & weight[DW-1]}}, weight[DW-1:HW]};
   end

   // The three products, truncated to their exact result widths.
   always_comb begin
      full_p_s = full_n_s * full_w_s;
      lo_p_s   = lo_n_s * lo_w_s;
      hi_p_s   = hi_n_s * hi_w_s;
   end

   // Result selection by mode.
   always_comb begin
      result = {RW{1'b0}};
      case (mode)
         MODE_FULL: result = full_p_s;
         MODE_HALF: result = {hi_p_s, lo_p_s};
         default:   result = {RW{1'b0}};
      endcase
   end

endmodule

// File: rtl/pe_mult_pipe.sv
// -----------------------------------------------------------------------------
// pe_mult_pipe
// LANES parallel multipliers followed by an elastic STAGES-deep pipeline.
// The multiply happens combinationally in front of stage 0; the later stages
// only delay the products. Each stage holds one valid bit and one beat.
//   clk          in   1             rising-edge clock
//   rst_n        in   1             asynchronous active-low reset
//   in_vld       in   1             input beat valid
//   in_rdy       out  1             beat can be accepted (combinational from out_rdy)
//   mult_mode    in   1             MODE_FULL / MODE_HALF for this beat
//   mult_sign    in   1             signed (1) / unsigned (0) for this beat
//   mult_neuron  in   LANES*DW      lane i at [i*DW +: DW]
//   mult_weight  in   LANES*DW      lane i at [i*DW +: DW]
//   out_vld      out  1             result beat valid (last stage valid)
//   out_rdy      in   1             downstream accepts the result
//   mult_result  out  LANES*2*DW    lane i at [i*2*DW +: 2*DW]
//   busy         out  1             any stage holds a beat
// -----------------------------------------------------------------------------
module pe_mult_pipe
   import pe_pkg::*;
#(
   parameter int LANES  = PE_LANES,
   parameter int DW     = PE_DW,
   parameter int STAGES = 2
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_vld,
   output logic                          in_rdy,
   input  logic                          mult_mode,
   input  logic                          mult_sign,
   input  logic [LANES*DW-1:0]           mult_neuron,
   input  logic [LANES*DW-1:0]           mult_weight,
   output logic                          out_vld,
   input  logic                          out_rdy,
   output logic [LANES*res_w(DW)-1:0]    mult_result,
   output logic                          busy
);

   localparam int RW = res_w(DW);
   localparam int BW = LANES * RW;

   logic [BW-1:0]     prod_s;
   logic [STAGES-1:0] adv_s;
   logic              in_rdy_s;

   logic [STAGES-1:0] vld_q;
   logic [STAGES-1:0] vld_d;
   logic [BW-1:0]     data_q [STAGES];
   logic [BW-1:0]     data_d [STAGES];

   genvar g;
   generate
      for (g = 0; g < LANES; g++) begin : g_lane
         pe_mult_lane #(
            .DW (DW)
         ) u_lane (
            .mode   (mult_mode),
            .sign   (mult_sign),
            .neuron (mult_neuron[g*DW +: DW]),
            .weight (mult_weight[g*DW +: DW]),
            .result (prod_s[g*RW +: RW])
         );
      end
   endgenerate

   // Advance chain, evaluated from the output backwards: a stage advances when
   // it is full and the slot after it is free; a slot is free when it is empty
   // or its own occupant advances. The free flag in front of stage 0 is in_rdy.
   always_comb begin
      logic free_v;
      free_v = out_rdy;
      adv_s  = {STAGES{1'b0}};
      for (int k = STAGES - 1; k >= 0; k--) begin
         adv_s[k] = vld_q[k] & free_v;
         free_v   = ~vld_q[k] | adv_s[k];
      end
      in_rdy_s = free_v;
   end

   // Next stage contents. A free stage takes whatever the previous stage holds,
   // including a bubble, which is how empty slots collapse under backpressure.
   // Data only moves with a valid beat so the held value stays put otherwise.
   always_comb begin
      vld_d  = vld_q;
      data_d = data_q;
      if (in_rdy_s) begin
         vld_d[0] = in_vld;
         if (in_vld) begin
            data_d[0] = prod_s;
         end else begin
            data_d[0] = data_q[0];
         end
      end else begin
         vld_d[0]  = vld_q[0];
         data_d[0] = data_q[0];
      end
      for (int k = 1; k < STAGES; k++) begin
         if (~vld_q[k] | adv_s[k]) begin
            vld_d[k] = vld_q[k-1];
            if (vld_q[k-1]) begin
               data_d[k] = data_q[k-1];
            end else begin
               data_d[k] = data_q[k];
            end
         end else begin
            vld_d[k]  = vld_q[k];
            data_d[k] = data_q[k];
         end
      end
   end

   // Stage valid and data registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= {STAGES{1'b0}};
         for (int k = 0; k < STAGES; k++) begin
            data_q[k] <= {BW{1'b0}};
         end
      end else begin
         vld_q <= vld_d;
         for (int k = 0; k < STAGES; k++) begin
            data_q[k] <= data_d[k];
         end
      end
   end

   assign in_rdy      = in_rdy_s;
   assign out_vld     = vld_q[STAGES-1];
   assign mult_result = data_q[STAGES-1];
   assign busy        = |vld_q;

endmodule

// File: tb/tb_pe_mult_pipe.sv
// -----------------------------------------------------------------------------
// tb_pe_mult_pipe
// Bench for pe_mult_pipe: a default instance (32 lanes, 2 stages) with a
// queue-based scoreboard, and a 4-lane single-stage instance checked cycle by
// cycle. Expected results come from integer arithmetic on the operand values.
// -----------------------------------------------------------------------------
module tb_pe_mult_pipe;

   localparam int LA = 32;
   localparam int DW = 16;
   localparam int RW = 32;
   localparam int BW = LA * RW;
   localparam int LB = 4;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   // default instance
   logic            in_vld, in_rdy, mode, sign, out_vld, out_rdy, busy;
   logic [LA*DW-1:0] neu, wgt;
   logic [BW-1:0]    res;

   // small single-stage instance
   logic            in_vld_b, in_rdy_b, mode_b, sign_b, out_vld_b, out_rdy_b, busy_b;
   logic [LB*DW-1:0] neu_b, wgt_b;
   logic [LB*RW-1:0] res_b;

   pe_mult_pipe #(.LANES(LA), .DW(DW), .STAGES(2)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy),
      .mult_mode(mode), .mult_sign(sign), .mult_neuron(neu), .mult_weight(wgt),
      .out_vld(out_vld), .out_rdy(out_rdy), .mult_result(res), .busy(busy)
   );

   pe_mult_pipe #(.LANES(LB), .DW(DW), .STAGES(1)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .in_vld(in_vld_b), .in_rdy(in_rdy_b),
      .mult_mode(mode_b), .mult_sign(sign_b), .mult_neuron(neu_b), .mult_weight(wgt_b),
      .out_vld(out_vld_b), .out_rdy(out_rdy_b), .mult_result(res_b), .busy(busy_b)
   );

   int checks = 0;
   int errors = 0;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Integer value of an operand field, honouring signedness.
   function automatic longint opval(input logic [15:0] x, input int width, input logic s);
      longint v;
      v = longint'(x) & ((64'd1 << width) - 64'd1);
      if (s && v[width-1]) v = v - (64'sd1 <<< width);
      return v;
   endfunction

   function automatic logic [31:0] ref_lane(input logic m, input logic s,
                                            input logic [15:0] n, input logic [15:0] w);
      longint p, q;
      logic [31:0] r;
      if (!m) begin
         p = opval(n, 16, s) * opval(w, 16, s);
         r = p[31:0];
      end else begin
         p = opval({8'h00, n[7:0]}, 8, s) * opval({8'h00, w[7:0]}, 8, s);
         q = opval({8'h00, n[15:8]}, 8, s) * opval({8'h00, w[15:8]}, 8, s);
         r = {q[15:0], p[15:0]};
      end
      return r;
   endfunction

   function automatic logic [BW-1:0] ref_vec(input logic m, input logic s,
                                             input logic [LA*DW-1:0] n, input logic [LA*DW-1:0] w);
      logic [BW-1:0] v;
      for (int l = 0; l < LA; l++) v[l*RW +: RW] = ref_lane(m, s, n[l*DW +: DW], w[l*DW +: DW]);
      return v;
   endfunction

   // Scoreboard for the default instance: record accepted beats, compare emitted ones.
   logic [BW-1:0] exp_q[$];
   logic [BW-1:0] mon_e;

   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
      end else begin
         if (out_vld && out_rdy) begin
            if (exp_q.size() == 0) begin
               check_val("sb_spurious_beat", 64'd1, 64'd0);
            end else begin
               mon_e = exp_q.pop_front();
               for (int l = 0; l < LA; l++)
                  check_val($sformatf("sb_lane%0d", l), 64'(res[l*RW +: RW]), 64'(mon_e[l*RW +: RW]));
            end
         end
         if (in_vld && in_rdy) exp_q.push_back(ref_vec(mode, sign, neu, wgt));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_ops();
      for (int l = 0; l < LA; l++) begin
         neu[l*DW +: DW] = 16'($urandom);
         wgt[l*DW +: DW] = 16'($urandom);
      end
   endtask

   // Single beat into an empty pipeline: checks the 2-edge latency and lane 0.
   task automatic one_beat(input string tag, input logic m, input logic s,
                           input logic [15:0] n0, input logic [15:0] w0, input logic [31:0] exp0);
      rand_ops();
      neu[15:0] = n0;
      wgt[15:0] = w0;
      mode      = m;
      sign      = s;
      in_vld    = 1'b1;
      out_rdy   = 1'b1;
      check_val({tag, "_in_rdy"}, 64'(in_rdy), 64'd1);
      tick();
      in_vld = 1'b0;
      check_val({tag, "_early_vld"}, 64'(out_vld), 64'd0);
      tick();
      check_val({tag, "_out_vld"}, 64'(out_vld), 64'd1);
      check_val({tag, "_lane0"}, 64'(res[31:0]), 64'(exp0));
      tick();
   endtask

   logic          acc;
   logic          seen;
   logic [BW-1:0] cap;
   int            sent;
   int            hold;
   logic          m_s, s_s;
   logic [LB*DW-1:0] n_s, w_s;
   logic [31:0]   e_l;

   initial begin
      rst_n = 1'b0;
      in_vld = 1'b0; mode = 1'b0; sign = 1'b0; out_rdy = 1'b1; neu = '0; wgt = '0;
      in_vld_b = 1'b0; mode_b = 1'b0; sign_b = 1'b0; out_rdy_b = 1'b1; neu_b = '0; wgt_b = '0;
      tick(); tick();
      check_val("rst_out_vld", 64'(out_vld), 64'd0);
      check_val("rst_busy", 64'(busy), 64'd0);
      check_val("rst_result_zero", 64'(res == '0), 64'd1);
      check_val("rst_b_out_vld", 64'(out_vld_b), 64'd0);
      rst_n = 1'b1;
      tick();
      check_val("rel_in_rdy", 64'(in_rdy), 64'd1);
      check_val("rel_out_vld", 64'(out_vld), 64'd0);

      // directed operand cases
      one_beat("full_s_neg", 1'b0, 1'b1, 16'hFFFF, 16'h0002, 32'hFFFFFFFE);
      one_beat("full_u_max", 1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001);
      one_beat("full_s_max", 1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 32'h00000001);
      one_beat("half_s",     1'b1, 1'b1, 16'h7F80, 16'h0202, 32'h00FEFF00);
      one_beat("half_u",     1'b1, 1'b0, 16'h7F80, 16'h0202, 32'h00FE0100);

      // backpressure: 6 beats alternating mode, out_rdy low for 4 cycles
      sent = 0; hold = 0; seen = 1'b0; cap = '0;
      out_rdy = 1'b1;
      rand_ops(); mode = 1'b0; sign = 1'($urandom); in_vld = 1'b1;
      for (int c = 0; c < 60 && (sent < 6 || exp_q.size() > 0); c++) begin
         @(negedge clk);
         acc = in_vld && in_rdy;
         if (!out_rdy) begin
            hold++;
            check_val("bp_result_stable", 64'(res == cap), 64'd1);
            check_val("bp_out_vld_held", 64'(out_vld), 64'd1);
            if (hold == 4) check_val("bp_in_rdy_low", 64'(in_rdy), 64'd0);
         end else if (out_vld && !seen) begin
            seen = 1'b1;
         end
         @(posedge clk); #1;
         if (acc) begin
            sent++;
            if (sent < 6) begin
               rand_ops(); mode = sent[0]; sign = 1'($urandom);
            end else begin
               in_vld = 1'b0;
            end
         end
         if (hold == 4) begin
            out_rdy = 1'b1;
            hold = 5;
         end else if (seen && hold == 0 && out_rdy) begin
            out_rdy = 1'b0;
            cap = res;
         end
      end
      check_val("bp_sent", 64'(sent), 64'd6);
      check_val("bp_hold_seen", 64'(hold), 64'd5);
      check_val("bp_drained", 64'(exp_q.size()), 64'd0);

      // random stream with random backpressure
      sent = 0; in_vld = 1'b0;
      for (int c = 0; c < 600 && (sent < 40 || exp_q.size() > 0); c++) begin
         @(negedge clk);
         acc = in_vld && in_rdy;
         @(posedge clk); #1;
         if (acc) sent++;
         if (acc || !in_vld) begin
            if (sent < 40 && $urandom_range(3, 0) != 0) begin
               rand_ops(); mode = 1'($urandom); sign = 1'($urandom); in_vld = 1'b1;
            end else begin
               in_vld = 1'b0;
            end
         end
         out_rdy = ($urandom_range(3, 0) != 0);
      end
      in_vld = 1'b0;
      check_val("rs_count", 64'(sent), 64'd40);
      check_val("rs_drained", 64'(exp_q.size()), 64'd0);

      // reset with two beats in flight
      out_rdy = 1'b0;
      tick();
      rand_ops(); in_vld = 1'b1;
      tick();
      rand_ops();
      tick();
      in_vld = 1'b0;
      check_val("rm_out_vld_before", 64'(out_vld), 64'd1);
      check_val("rm_busy_before", 64'(busy), 64'd1);
      #1 rst_n = 1'b0;
      #1;
      check_val("rm_out_vld_async", 64'(out_vld), 64'd0);
      check_val("rm_result_zero", 64'(res == '0), 64'd1);
      check_val("rm_busy_async", 64'(busy), 64'd0);
      @(posedge clk); #2 rst_n = 1'b1;
      out_rdy = 1'b1;
      for (int c = 0; c < 5; c++) begin
         tick();
         check_val("rm_no_residual", 64'(out_vld), 64'd0);
      end

      // single-stage 4-lane instance: one result per cycle, one-edge latency
      out_rdy_b = 1'b1;
      for (int c = 0; c < 50; c++) begin
         for (int l = 0; l < LB; l++) begin
            neu_b[l*DW +: DW] = 16'($urandom);
            wgt_b[l*DW +: DW] = 16'($urandom);
         end
         mode_b = 1'($urandom); sign_b = 1'($urandom); in_vld_b = 1'b1;
         m_s = mode_b; s_s = sign_b; n_s = neu_b; w_s = wgt_b;
         check_val("b_in_rdy", 64'(in_rdy_b), 64'd1);
         tick();
         check_val("b_out_vld", 64'(out_vld_b), 64'd1);
         for (int l = 0; l < LB; l++) begin
            e_l = ref_lane(m_s, s_s, n_s[l*DW +: DW], w_s[l*DW +: DW]);
            check_val($sformatf("b_lane%0d", l), 64'(res_b[l*RW +: RW]), 64'(e_l));
         end
      end
      in_vld_b = 1'b0;
      tick();
      check_val("b_idle_vld", 64'(out_vld_b), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout expected=finish");
      $fatal(1, "simulation time limit reached");
   end

endmodule
